pc_sequencer: RTL and testbench

//   Owns the architectural program counter and decides its next value each cycle.
//   - Inputs: sequential increment, branch/jump redirects, stall/halt control, optional interrupt entry.
//   - Sits between the decode/execute control and the instruction-memory fetch port.
//   - The PC is word-addressed: sequential advance is +1.

---
 rtl/pc_seq_pkg.sv | 28 ++
 rtl/pc_next_mux.sv | 35 +++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_seq_pkg : state and next-pc select encodings for pc_sequencer     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_IRQ  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_INC  = 3'd1,
    SEL_BR   = 3'd2,
    SEL_JMP  = 3'd3,
    SEL_VEC  = 3'd4
  } sel_e;

  function automatic logic is_redirect(input sel_e s);
    return (s == SEL_BR) || (s == SEL_JMP) || (s == SEL_VEC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_next_mux : combinational next-pc select and +1 increment          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  sel_e            sel,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] br_target,
  input  logic [PC_W-1:0] jmp_target,
  input  logic [PC_W-1:0] vec,
  output logic [PC_W-1:0] pc_inc,
  output logic [PC_W-1:0] pc_next
);

  // Wraps silently at the top of the address space.
  assign pc_inc = pc + {{(PC_W-1){1'b0}}, 1'b1};

  always_comb begin
    pc_next = pc;
    case (sel)
      SEL_INC: pc_next = pc_inc;
      SEL_BR:  pc_next = br_target;
      SEL_JMP: pc_next = jmp_target;
      SEL_VEC: pc_next = vec;
      default: pc_next = pc;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_sequencer : program counter owner (boot/run/halt/irq sequencing)  |
// | Optional interrupt entry enabled by defining PC_IRQ_EN. Rev 1.0      |
// +----------------------------------------------------------------------+
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] IRQ_VECTOR = PC_W'(4)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_ready,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            halt,
  input  logic            resume,
  input  logic            irq,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            redirect,
  output logic [PC_W-1:0] epc,
  output logic [1:0]      state
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, epc_q, epc_d, pc_inc;
  logic              pc_valid_q, pc_valid_d;
  logic              redirect_q, redirect_d;
  logic              irq_req;
  sel_e              sel;

  pc_next_mux #(.PC_W(PC_W)) u_next_mux (
    .sel        (sel),
    .pc         (pc_q),
    .br_target  (branch_target),
    .jmp_target (jump_target),
    .vec        (IRQ_VECTOR),
    .pc_inc     (pc_inc),
    .pc_next    (pc_d)
  );

`ifdef PC_IRQ_EN
  logic irq_armed_q, irq_armed_d;

  // Edge re-arm: one taken entry disarms until irq is seen low.
  assign irq_req = irq & irq_armed_q;

  always_comb begin
    irq_armed_d = irq_armed_q;
    if (sel == SEL_VEC) irq_armed_d = 1'b0;
    else if (!irq)      irq_armed_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) irq_armed_q <= 1'b1;
    else        irq_armed_q <= irq_armed_d;
  end
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign irq_req    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel     = SEL_HOLD;
    epc_d   = epc_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN, ST_IRQ: begin
        if (state_q == ST_RUN && irq_req) begin
          sel     = SEL_VEC;
          state_d = ST_IRQ;
          if (branch_taken) epc_d = branch_target;
          else if (jump)    epc_d = jump_target;
          else              epc_d = pc_q;
        end else begin
          state_d = ST_RUN;
          if (branch_taken)                 sel = SEL_BR;
          else if (jump)                    sel = SEL_JMP;
          else if (halt)                    state_d = ST_HALT;
          else if (!stall && fetch_ready)   sel = SEL_INC;
        end
      end
      ST_HALT: begin
        if (irq_req) begin
          sel     = SEL_VEC;
          state_d = ST_IRQ;
          epc_d   = pc_inc;
        end else if (resume) begin
          sel     = SEL_INC;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
`ifndef PC_IRQ_EN
    epc_d = '0;
`endif
  end

  assign pc_valid_d = (state_d == ST_RUN) || (state_d == ST_IRQ);
  assign redirect_d = is_redirect(sel);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      epc_q      <= '0;
      pc_valid_q <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      pc_valid_q <= pc_valid_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign redirect = redirect_q;
  assign epc      = epc_q;
  assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_sequencer : directed bench with reference model for pc_sequencer|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] IRQ_V  = 32'h0000_0004;
`ifdef PC_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, fetch_ready, stall, branch_taken, jump, halt, resume, irq;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, epc;
  logic        pc_valid, redirect;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;

  pc_sequencer #(.PC_W(32), .RESET_PC(RST_PC), .IRQ_VECTOR(IRQ_V)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .halt(halt), .resume(resume),
    .irq(irq), .pc(pc), .pc_valid(pc_valid), .redirect(redirect),
    .epc(epc), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 boot, 1 run, 2 halted, 3 interrupt entry.
  int          m_mode;
  logic [31:0] m_pc, m_epc;
  logic        m_valid, m_redir, m_armed;
  bit          started = 1'b0;

  always @(posedge clk) begin
    int          mode;
    logic [31:0] npc, nepc;
    logic        rd, armed;
    mode = m_mode; npc = m_pc; nepc = m_epc; rd = 1'b0; armed = m_armed;
    if (!rst_n) begin
      mode = 0; npc = RST_PC; nepc = 32'h0; armed = 1'b1;
    end else if (mode == 0) begin
      mode = 1;
    end else if (mode == 2) begin
      if (IRQ_EN && irq && armed) begin
        nepc = m_pc + 32'd1; npc = IRQ_V; rd = 1'b1; mode = 3; armed = 1'b0;
      end else if (resume) begin
        npc = m_pc + 32'd1; mode = 1;
      end
    end else begin
      if (IRQ_EN && mode == 1 && irq && armed) begin
        nepc = branch_taken ? branch_target : (jump ? jump_target : m_pc);
        npc = IRQ_V; rd = 1'b1; mode = 3; armed = 1'b0;
      end else begin
        mode = 1;
        if (branch_taken)              begin npc = branch_target; rd = 1'b1; end
        else if (jump)                 begin npc = jump_target;   rd = 1'b1; end
        else if (halt)                 mode = 2;
        else if (!stall && fetch_ready) npc = m_pc + 32'd1;
      end
    end
    if (rst_n && !irq) armed = 1'b1;
    m_mode  <= mode;
    m_pc    <= npc;
    m_epc   <= nepc;
    m_redir <= rd;
    m_armed <= armed;
    m_valid <= (mode == 1) || (mode == 3);
    started <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("model_pc",       pc,              m_pc);
      chk("model_pc_valid", {31'b0, pc_valid}, {31'b0, m_valid});
      chk("model_redirect", {31'b0, redirect}, {31'b0, m_redir});
      chk("model_epc",      epc,             m_epc);
      chk("model_state",    {30'b0, state},  m_mode[31:0]);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; fetch_ready = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    jump = 1'b0; halt = 1'b0; resume = 1'b0; irq = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;
    tick(2);
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", {30'b0, state}, 32'd0);
    chk("rst_valid", {31'b0, pc_valid}, 32'd0);
    chk("rst_redirect", {31'b0, redirect}, 32'd0);

    // T1: boot then sequential fetch
    rst_n = 1'b1; fetch_ready = 1'b1;
    tick(); chk("t1_state_run", {30'b0, state}, 32'd1);
    chk("t1_valid", {31'b0, pc_valid}, 32'd1);
    chk("t1_pc0", pc, 32'h0);
    tick(); chk("t1_pc1", pc, 32'h1);
    tick(); chk("t1_pc2", pc, 32'h2);
    tick(3); chk("t1_pc5", pc, 32'h5);

    // T2: stall holds
    stall = 1'b1;
    tick(); chk("t2_hold_a", pc, 32'h5);
    tick(); chk("t2_hold_b", pc, 32'h5);
    tick(); chk("t2_hold_c", pc, 32'h5);
    stall = 1'b0;
    tick(); chk("t2_release", pc, 32'h6);

    // T3: branch beats jump
    tick(2); chk("t3_pc8", pc, 32'h8);
    branch_taken = 1'b1; branch_target = 32'h40; jump = 1'b1; jump_target = 32'h80;
    tick(); chk("t3_branch", pc, 32'h40);
    chk("t3_redirect", {31'b0, redirect}, 32'd1);
    branch_taken = 1'b0; jump = 1'b0;
    tick(); chk("t3_after", pc, 32'h41);
    chk("t3_redirect_drop", {31'b0, redirect}, 32'd0);

    // T4: wrap at top of address space
    jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    tick(); jump = 1'b0;
    chk("t4_top", pc, 32'hFFFF_FFFF);
    tick(); chk("t4_wrap", pc, 32'h0);
    chk("t4_no_redirect", {31'b0, redirect}, 32'd0);

    // T5: halt, ignored jump, resume
    jump = 1'b1; jump_target = 32'h10;
    tick(); jump = 1'b0; halt = 1'b1;
    tick(); halt = 1'b0;
    chk("t5_halt_state", {30'b0, state}, 32'd2);
    chk("t5_halt_valid", {31'b0, pc_valid}, 32'd0);
    chk("t5_halt_pc", pc, 32'h10);
    jump = 1'b1; jump_target = 32'h99;
    tick(); jump = 1'b0;
    chk("t5_jump_ignored", pc, 32'h10);
    resume = 1'b1;
    tick(); resume = 1'b0;
    chk("t5_resume_pc", pc, 32'h11);
    chk("t5_resume_valid", {31'b0, pc_valid}, 32'd1);

    // Redirect accepted while fetch is blocked
    fetch_ready = 1'b0; stall = 1'b1;
    tick(); chk("blk_hold", pc, 32'h11);
    branch_taken = 1'b1; branch_target = 32'h200;
    tick(); branch_taken = 1'b0;
    chk("blk_branch", pc, 32'h200);
    fetch_ready = 1'b1; stall = 1'b0;
    tick();

`ifdef PC_IRQ_EN
    // T6: level irq, single entry, re-arm on deassert
    jump = 1'b1; jump_target = 32'h20;
    tick(); jump = 1'b0; stall = 1'b1; irq = 1'b1;
    tick(); stall = 1'b0;
    chk("t6_entry_state", {30'b0, state}, 32'd3);
    chk("t6_entry_pc", pc, 32'h4);
    chk("t6_epc", epc, 32'h20);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("t6_single_entry", {31'b0, (state == 2'd3)}, 32'd0);
    end
    irq = 1'b0;
    tick(); irq = 1'b1;
    tick(); chk("t6_second_entry", {30'b0, state}, 32'd3);
    chk("t6_second_pc", pc, 32'h4);
    irq = 1'b0; halt = 1'b1;
    tick(); halt = 1'b0; irq = 1'b1; resume = 1'b1;
    tick(); irq = 1'b0; resume = 1'b0;
    chk("t6_halt_irq_state", {30'b0, state}, 32'd3);
    tick();
`else
    irq = 1'b1;
    tick(3);
    chk("noirq_epc", epc, 32'h0);
    irq = 1'b0;
`endif

    // Reset while halted
    halt = 1'b1;
    tick(); halt = 1'b0; rst_n = 1'b0;
    tick(); chk("rst_halt_state", {30'b0, state}, 32'd0);
    chk("rst_halt_pc", pc, 32'h0);
    rst_n = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
